exec_core: RTL and testbench
============================

# exec_core

Execution-side datapath block for the single-bus 32-bit processor. It bundles three functions:
- the ALU, whose 64-bit result feeds the Z register;
- the branch-condition evaluator, which produces do_branch from IR and the CON register;
- the memory data register (MDR), which selects between the bus and RAM read data.

The control FSM drives every enable and op line. The ALU is combinational except MUL/DIV, which are sequential and launched by `start`.

## Interface
- No parameters.
- clk  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-low; clears MDR, MUL/DIV engine and ALU result holding state.
- alu_a  in  32  operand A (Y register).
- alu_b  in  32  operand B (bus).
- op_add, op_sub, op_mul, op_div, op_shr, op_shl, op_ror, op_rol, op_and, op_or, op_neg, op_not, op_inc  in  1 each  operation selects.
- start  in  1  MUL/DIV launch.
- alu_c  out  64  result to Z.
- alu_done  out  1  MUL/DIV result valid.
- ir  in  32  instruction register.
- con_value  in  32  CON register contents.
- do_branch  out  1  branch condition true.
- mdr_in  in  1  MDR load enable.
- mdr_read  in  1  1: load mem_data_in; 0: load bus.
- bus_in  in  32  bus.
- mem_data_in  in  32  RAM read data.
- mdr_q  out  32  MDR contents.

## Operation
- **Op priority.** More than one op line high: lowest-listed-first wins, in the order add, sub, mul, div, shr, shl, ror, rol, and, or, neg, not, inc.
- **No op.** No op line high: alu_c = 0.
- **Single-result ops.** alu_c[31:0] holds the result and alu_c[63:32] = 0. All arithmetic wraps mod 2^32.
  - ADD: A+B.
  - SUB: A−B.
  - AND: A&B.
  - OR: A|B.
  - SHR: logical right shift of A by B[4:0].
  - SHL: left shift of A by B[4:0].
  - ROR / ROL: rotate A by B[4:0].
  - NEG: −B (two's complement).
  - NOT: ~B.
  - INC: B+1.
- **MUL.** Signed A×B, full 64-bit product on alu_c.
- **DIV.** Signed A/B.
  - alu_c[31:0] = quotient, truncated toward zero.
  - alu_c[63:32] = remainder, carrying the sign of A.
  - B=0: quotient 32'hFFFFFFFF, remainder A.
  - −2^31/−1: quotient 32'h80000000, remainder 0.
- **MUL/DIV engine.** Iterative (shift-add / restoring), states IDLE → BUSY → DONE.
  - IDLE→BUSY on a rising edge of start (start=1 while start was 0 in the previous cycle) with op_mul or op_div high. Operands and op are captured at that edge.
  - BUSY lasts 32 cycles, then DONE: result is registered and alu_done=1.
  - DONE→BUSY on a new start rising edge; otherwise DONE holds.
  - While op_mul/op_div is selected, alu_c shows the registered result. This is 0 after reset and the previous result while BUSY.
  - A start edge while BUSY is ignored.
  - start held high over several cycles launches exactly one operation.
- **Branch condition.** Combinational on ir[20:19]:
  - 00: do_branch = (con_value==0).
  - 01: do_branch = (con_value!=0).
  - 10: do_branch = (con_value[31]==0).
  - 11: do_branch = (con_value[31]==1).
- **MDR.** On a clock edge with mdr_in=1, loads mem_data_in if mdr_read=1, else bus_in. It holds otherwise. mdr_q always drives the contents.

## Timing
- **Reset.** While reset=0:
  - mdr_q=0.
  - engine in IDLE, alu_done=0, registered result=0.
  - do_branch and the combinational alu_c remain functions of their inputs.
- **Combinational ops.** Zero latency: alu_c is valid in the same cycle as the inputs, sampled into Z at the next edge.
- **MUL/DIV latency.** alu_done rises at the 33rd rising edge after the edge that sampled the start rise. The result is stable on alu_c from then on. The FSM holds the op for ≥40 cycles, so the result is safely captured.
- **Mid-operation reset.** Reset asserted during BUSY aborts the operation. After release, the engine is in IDLE with result 0.
- **MDR latency.** A load is visible on mdr_q one cycle after the enabling edge.

## Test plan
- ADD 7+5 → 12. SUB 5−7 → alu_c=64'h00000000_FFFFFFFE. ROL 32'h80000001 by 1 → 32'h00000003. SHR 32'h80000000 by 4 → 32'h08000000. NEG 5 → 32'hFFFFFFFB. INC 32'hFFFFFFFF → 0.
- MUL −3×7: pulse start (held 4 cycles) → exactly one operation. alu_done at edge 33, alu_c=64'hFFFFFFFF_FFFFFFEB. start retrigger while BUSY is ignored.
- DIV −7/2 → LO 32'hFFFFFFFD, HI 32'hFFFFFFFF. DIV 9/0 → LO 32'hFFFFFFFF, HI 9.
- Branch with ir[20:19]=00/01/10/11 and con_value=0 → do_branch 1/0/1/0. With con_value=32'h80000000 → 0/1/0/1.
- MDR:
  - mdr_in=1, mdr_read=1, mem_data_in=32'hDEADBEEF → mdr_q next cycle = 32'hDEADBEEF.
  - mdr_read=0, bus_in=0x1234 → 0x1234.
  - mdr_in=0 → holds.
- Reset mid-DIV at cycle 10 → alu_done=0 and mdr_q=0 immediately. A new MUL after release completes normally.

Source files
------------

// File: rtl/exec_core.sv
// exec_core: execution-side datapath of the single-bus 32-bit processor.
//   - ALU: combinational ops plus an iterative signed MUL/DIV engine whose
//     64-bit result is shown on alu_c while op_mul/op_div is selected.
//   - Branch evaluator: do_branch from ir[20:19] and the CON register.
//   - MDR: loads RAM read data or the bus on mdr_in.
// Ports:
//   clk, reset (async, active-low)
//   alu_a, alu_b, op_* selects, start      -> alu_c[63:0], alu_done
//   ir, con_value                          -> do_branch
//   mdr_in, mdr_read, bus_in, mem_data_in  -> mdr_q
module exec_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic        op_add,
    input  logic        op_sub,
    input  logic        op_mul,
    input  logic        op_div,
    input  logic        op_shr,
    input  logic        op_shl,
    input  logic        op_ror,
    input  logic        op_rol,
    input  logic        op_and,
    input  logic        op_or,
    input  logic        op_neg,
    input  logic        op_not,
    input  logic        op_inc,
    input  logic        start,
    output logic [63:0] alu_c,
    output logic        alu_done,
    input  logic [31:0] ir,
    input  logic [31:0] con_value,
    output logic        do_branch,
    input  logic        mdr_in,
    input  logic        mdr_read,
    input  logic [31:0] bus_in,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mdr_q
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Two's-complement magnitude; -2^31 maps to 32'h80000000 as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    logic [1:0]  state_r;
    logic [5:0]  cnt_r;
    logic        start_d_r;
    logic        is_div_r;
    logic        sign_a_r;
    logic        sign_b_r;
    logic        b_zero_r;
    logic [31:0] a_r;
    logic [31:0] opnd_r;     // |A| for MUL (addend), |B| for DIV (divisor)
    logic [63:0] acc_r;      // MUL: {partial, multiplier}; DIV: {rem, quo}
    logic [63:0] result_r;
    logic        done_r;
    logic [31:0] mdr_r;

    logic        launch_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_rr_s;
    logic [32:0] div_diff_s;
    logic [63:0] step_s;
    logic [63:0] final_s;
    logic [63:0] alu_c_s;
    logic [63:0] rot_r_s;
    logic [63:0] rot_l_s;
    logic [4:0]  shamt_s;
    logic        branch_s;
    logic        unused_ir_s;

    // Only the rising edge of start (with MUL/DIV selected) launches an operation.
    assign launch_s = start & ~start_d_r & (op_mul | op_div);

    // One shift-add (MUL) or restoring-subtract (DIV) iteration on unsigned magnitudes.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        div_rr_s   = acc_r[63:31];
        div_diff_s = div_rr_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (!div_diff_s[32]) begin
                step_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
            end else begin
                step_s = {div_rr_s[31:0], acc_r[30:0], 1'b0};
            end
        end else begin
            step_s = {mul_sum_s, acc_r[31:1]};
        end
    end

    // Sign correction of the unsigned result; divide-by-zero is forced explicitly.
    always_comb begin
        if (!is_div_r) begin
            final_s = (sign_a_r ^ sign_b_r) ? (64'd0 - acc_r) : acc_r;
        end else if (b_zero_r) begin
            final_s = {a_r, 32'hFFFF_FFFF};
        end else begin
            final_s[31:0]  = (sign_a_r ^ sign_b_r) ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
            final_s[63:32] = sign_a_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
        end
    end

    // MUL/DIV engine: IDLE/DONE -> BUSY on launch, 32 iterations, then finalize.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 6'd0;
            start_d_r <= 1'b0;
            is_div_r  <= 1'b0;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            b_zero_r  <= 1'b0;
            a_r       <= 32'd0;
            opnd_r    <= 32'd0;
            acc_r     <= 64'd0;
            result_r  <= 64'd0;
            done_r    <= 1'b0;
        end else begin
            start_d_r <= start;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (launch_s) begin
                        state_r  <= ST_BUSY;
                        cnt_r    <= 6'd0;
                        done_r   <= 1'b0;
                        is_div_r <= ~op_mul;
                        sign_a_r <= alu_a[31];
                        sign_b_r <= alu_b[31];
                        b_zero_r <= (alu_b == 32'd0);
                        a_r      <= alu_a;
                        if (op_mul) begin
                            opnd_r <= abs32(alu_a);
                            acc_r  <= {32'd0, abs32(alu_b)};
                        end else begin
                            opnd_r <= abs32(alu_b);
                            acc_r  <= {32'd0, abs32(alu_a)};
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_BUSY: begin
                    // Iterations on counts 0..31; count 32 is the finalize edge.
                    if (cnt_r == 6'd32) begin
                        result_r <= final_s;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        acc_r <= step_s;
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_done = done_r;
    assign shamt_s  = alu_b[4:0];

    // Combinational ALU with fixed priority add > sub > mul > div > shr > ... > inc.
    always_comb begin
        rot_r_s = {alu_a, alu_a} >> shamt_s;
        rot_l_s = {alu_a, alu_a} << shamt_s;
        alu_c_s = 64'd0;
        if (op_add) begin
            alu_c_s = {32'd0, alu_a + alu_b};
        end else if (op_sub) begin
            alu_c_s = {32'd0, alu_a - alu_b};
        end else if (op_mul || op_div) begin
            alu_c_s = result_r;
        end else if (op_shr) begin
            alu_c_s = {32'd0, alu_a >> shamt_s};
        end else if (op_shl) begin
            alu_c_s = {32'd0, alu_a << shamt_s};
        end else if (op_ror) begin
            alu_c_s = {32'd0, rot_r_s[31:0]};
        end else if (op_rol) begin
            alu_c_s = {32'd0, rot_l_s[63:32]};
        end else if (op_and) begin
            alu_c_s = {32'd0, alu_a & alu_b};
        end else if (op_or) begin
            alu_c_s = {32'd0, alu_a | alu_b};
        end else if (op_neg) begin
            alu_c_s = {32'd0, 32'd0 - alu_b};
        end else if (op_not) begin
            alu_c_s = {32'd0, ~alu_b};
        end else if (op_inc) begin
            alu_c_s = {32'd0, alu_b + 32'd1};
        end else begin
            alu_c_s = 64'd0;
        end
    end

    assign alu_c = alu_c_s;

    // Branch condition select from the instruction's condition field.
    always_comb begin
        case (ir[20:19])
            2'b00:   branch_s = (con_value == 32'd0);
            2'b01:   branch_s = (con_value != 32'd0);
            2'b10:   branch_s = ~con_value[31];
            2'b11:   branch_s = con_value[31];
            default: branch_s = 1'b0;
        endcase
    end

    assign do_branch   = branch_s;
    assign unused_ir_s = ^{ir[31:21], ir[18:0]};

    // Memory data register: RAM data or bus on load enable, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdr_r <= 32'd0;
        end else if (mdr_in) begin
            mdr_r <= mdr_read ? mem_data_in : bus_in;
        end else begin
            mdr_r <= mdr_r;
        end
    end

    assign mdr_q = mdr_r;

endmodule

// File: tb/tb_exec_core.sv
// Self-checking bench for exec_core: directed plan vectors plus $urandom
// stimulus compared against arithmetic reference models.
module tb_exec_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_a, alu_b;
    logic [12:0] ops;          // bit 0 = add ... bit 12 = inc (priority order)
    logic        start;
    logic [63:0] alu_c;
    logic        alu_done;
    logic [31:0] ir, con_value;
    logic        do_branch;
    logic        mdr_in, mdr_read;
    logic [31:0] bus_in, mem_data_in;
    logic [31:0] mdr_q;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_md;      // expected registered MUL/DIV result
    logic [31:0] mdr_model;

    always #5 clk = ~clk;

    exec_core dut (
        .clk(clk), .reset(reset), .alu_a(alu_a), .alu_b(alu_b),
        .op_add(ops[0]), .op_sub(ops[1]), .op_mul(ops[2]), .op_div(ops[3]),
        .op_shr(ops[4]), .op_shl(ops[5]), .op_ror(ops[6]), .op_rol(ops[7]),
        .op_and(ops[8]), .op_or(ops[9]), .op_neg(ops[10]), .op_not(ops[11]),
        .op_inc(ops[12]), .start(start), .alu_c(alu_c), .alu_done(alu_done),
        .ir(ir), .con_value(con_value), .do_branch(do_branch),
        .mdr_in(mdr_in), .mdr_read(mdr_read), .bus_in(bus_in),
        .mem_data_in(mem_data_in), .mdr_q(mdr_q)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU: first set op line wins; MUL/DIV show the held result.
    function automatic logic [63:0] ref_alu(input logic [12:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] md);
        int s;
        int k;
        logic [31:0] r;
        s = int'(b[4:0]);
        k = -1;
        r = 32'd0;
        for (int i = 0; i < 13; i++) if (o[i] && k < 0) k = i;
        case (k)
            0:  r = a + b;
            1:  r = a - b;
            2, 3: return md;
            4:  r = a >> s;
            5:  r = a << s;
            6:  r = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            7:  r = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            8:  r = a & b;
            9:  r = a | b;
            10: r = 32'd0 - b;
            11: r = ~b;
            12: r = b + 32'd1;
            default: return 64'd0;
        endcase
        return {32'd0, r};
    endfunction

    // Reference MUL/DIV from signed 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input bit is_div, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = $signed(a);
        sb = $signed(b);
        if (!is_div) return 64'(sa * sb);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
    endfunction

    function automatic bit ref_branch(input logic [1:0] c, input logic [31:0] v);
        case (c)
            2'd0: return v == 32'd0;
            2'd1: return v != 32'd0;
            2'd2: return v[31] == 1'b0;
            default: return v[31] == 1'b1;
        endcase
    endfunction

    task automatic comb_check(input string tag, input logic [12:0] o,
                              input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        @(negedge clk);
        ops = o; alu_a = a; alu_b = b;
        #1;
        chk(tag, alu_c, exp);
    endtask

    // Launch one MUL/DIV and check done timing (edge 33) and the result.
    task automatic run_md(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit retrig);
        logic [63:0] exp;
        int early;
        exp = ref_md(is_div, a, b);
        early = 0;
        @(negedge clk);
        ops = is_div ? 13'b0_0000_0000_1000 : 13'b0_0000_0000_0100;
        alu_a = a; alu_b = b; start = 1'b1;
        @(posedge clk);                          // edge 0 samples the rise
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk); #1;
            if (alu_done !== 1'b0) early++;
            if (e == hold) start = 1'b0;
            if (retrig && e == 10) start = 1'b1;
            if (retrig && e == 11) start = 1'b0;
            if (e == 5) chk("md_busy_prev", alu_c, last_md);
        end
        chk("md_done_not_early", 64'(early), 64'd0);
        @(posedge clk); #1;
        chk("md_done_edge33", {63'd0, alu_done}, 64'd1);
        chk(is_div ? "div_result" : "mul_result", alu_c, exp);
        start = 1'b0;
        last_md = exp;
        repeat (3) @(posedge clk);
        #1;
        chk("md_done_holds", {alu_done, alu_c}, {1'b1, exp});
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ops = 13'd0; alu_a = 32'd0; alu_b = 32'd0;
        ir = 32'd0; con_value = 32'd0; mdr_in = 1'b0; mdr_read = 1'b0;
        bus_in = 32'd0; mem_data_in = 32'd0; last_md = 64'd0; mdr_model = 32'd0;

        // Reset state
        #12;
        chk("rst_mdr", {32'd0, mdr_q}, 64'd0);
        chk("rst_done", {63'd0, alu_done}, 64'd0);
        ops = 13'b0_0000_0000_0100; #1;
        chk("rst_mulresult", alu_c, 64'd0);
        chk("rst_branch_comb", {63'd0, do_branch}, 64'd1);
        @(negedge clk); reset = 1'b1; ops = 13'd0;
        #1 chk("no_op", alu_c, 64'd0);

        // Directed combinational vectors
        comb_check("add", 13'h0001, 32'd7, 32'd5, 64'd12);
        comb_check("sub", 13'h0002, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE);
        comb_check("rol", 13'h0080, 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0003);
        comb_check("shr", 13'h0010, 32'h8000_0000, 32'd4, 64'h0000_0000_0800_0000);
        comb_check("neg", 13'h0400, 32'd0, 32'd5, 64'h0000_0000_FFFF_FFFB);
        comb_check("inc", 13'h1000, 32'd0, 32'hFFFF_FFFF, 64'd0);
        comb_check("prio_add_sub", 13'h0003, 32'd9, 32'd4, 64'd13);

        // Random combinational ops, single and multiple selects
        for (int i = 0; i < 60; i++) begin
            logic [12:0] o;
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if (i % 2 == 0) o = 13'd1 << $urandom_range(0, 12);
            else o = 13'($urandom_range(0, 8191));
            comb_check("alu_rand", o, a, b, ref_alu(o, a, b, last_md));
        end

        // Branch conditions
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < 4; c++) begin
                logic [1:0] cc;
                cc = 2'(c);
                @(negedge clk);
                ir = 32'($urandom); ir[20:19] = cc;
                con_value = (v == 0) ? 32'd0 : 32'h8000_0000;
                #1 chk("branch_dir", {63'd0, do_branch}, {63'd0, ref_branch(cc, con_value)});
            end
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ir = $urandom;
            con_value = (i % 4 == 0) ? 32'd0 : $urandom;
            #1 chk("branch_rand", {63'd0, do_branch}, {63'd0, ref_branch(ir[20:19], con_value)});
        end

        // MDR
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mdr_in = 1'($urandom); mdr_read = 1'($urandom);
            bus_in = $urandom; mem_data_in = $urandom;
            if (mdr_in) mdr_model = mdr_read ? mem_data_in : bus_in;
            @(posedge clk); #1;
            chk("mdr_rand", {32'd0, mdr_q}, {32'd0, mdr_model});
        end
        @(negedge clk); mdr_in = 1'b1; mdr_read = 1'b1; mem_data_in = 32'hDEAD_BEEF;
        @(posedge clk); #1 chk("mdr_mem", {32'd0, mdr_q}, 64'h0000_0000_DEAD_BEEF);
        @(negedge clk); mdr_read = 1'b0; bus_in = 32'h0000_1234;
        @(posedge clk); #1 chk("mdr_bus", {32'd0, mdr_q}, 64'h0000_0000_0000_1234);
        @(negedge clk); mdr_in = 1'b0; bus_in = 32'h5555_AAAA; mem_data_in = 32'h1111_2222;
        @(posedge clk); #1 chk("mdr_hold", {32'd0, mdr_q}, 64'h0000_0000_0000_1234);

        // MUL/DIV
        run_md(1'b0, 32'hFFFF_FFFD, 32'd7, 4, 1'b1);
        run_md(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
        run_md(1'b1, 32'd9, 32'd0, 2, 1'b0);
        run_md(1'b1, 32'hFFFF_FFF0, 32'd0, 1, 1'b0);
        run_md(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
        run_md(1'b0, 32'h8000_0000, 32'h8000_0000, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_md(1'($urandom), $urandom, (i == 3) ? 32'($urandom_range(1, 9)) : $urandom,
                   $urandom_range(1, 6), 1'b0);
        end

        // Reset in the middle of a DIV
        @(negedge clk);
        ops = 13'b0_0000_0000_1000; alu_a = 32'hFFFF_FF9C; alu_b = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        #1;
        chk("midrst_done", {63'd0, alu_done}, 64'd0);
        chk("midrst_mdr", {32'd0, mdr_q}, 64'd0);
        chk("midrst_result", alu_c, 64'd0);
        last_md = 64'd0;
        @(negedge clk) reset = 1'b1;
        run_md(1'b0, 32'd12345, 32'hFFFF_FF00, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
